// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC/fetch control for a one-cycle-latency instruction memory; define FETCH_PERF_CNT_EN for transfer/stall counters
module fetch_sequencer #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              start,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  output logic              busy,
  output logic              halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]       perf_instr,
  output logic [15:0]       perf_stall
`endif
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HALT = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_fetch_q, pc_fetch_d, pend_pc_q, pend_pc_d;
  logic              pend_valid_q, pend_valid_d;
  logic              run, zero_word;

  // the word on mem_data belongs to pend_pc; a zero word means end of program
  always_comb begin
    run         = state_q == RUN;
    zero_word   = mem_data == '0;
    instr_valid = run & pend_valid_q & ~redirect & ~zero_word;
    instr       = mem_data;
    instr_pc    = pend_pc_q;
    busy        = run;
    halted      = state_q == HALT;
  end

  // fetch address and next state, priority redirect > halt > stall > advance
  always_comb begin
    state_d      = state_q;
    pc_fetch_d   = pc_fetch_q;
    pend_pc_d    = pend_pc_q;
    pend_valid_d = pend_valid_q;
    mem_addr     = RESET_PC;
    if (!run) begin
      if (start) begin
        state_d      = RUN;
        pend_pc_d    = RESET_PC;
        pend_valid_d = 1'b1;
        pc_fetch_d   = RESET_PC + 1'b1;
      end
    end else if (redirect) begin
      mem_addr     = redirect_addr;
      pend_pc_d    = redirect_addr;
      pend_valid_d = 1'b1;
      pc_fetch_d   = redirect_addr + 1'b1;
    end else if (pend_valid_q && zero_word) begin
      mem_addr     = pc_fetch_q;
      state_d      = HALT;
      pend_valid_d = 1'b0;
    end else if (stall && pend_valid_q) begin
      mem_addr = pend_pc_q;
    end else begin
      mem_addr     = pc_fetch_q;
      pend_pc_d    = pc_fetch_q;
      pend_valid_d = 1'b1;
      pc_fetch_d   = pc_fetch_q + 1'b1;
    end
  end

  // fetch state registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      pc_fetch_q   <= RESET_PC;
      pend_pc_q    <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_fetch_q   <= pc_fetch_d;
      pend_pc_q    <= pend_pc_d;
      pend_valid_q <= pend_valid_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_instr_q, perf_instr_d, perf_stall_q, perf_stall_d;
  logic        clr;

  // saturating counters, cleared whenever a start is accepted
  always_comb begin
    clr          = ~run & start;
    perf_instr_d = clr ? '0 : (instr_valid & ~stall & ~&perf_instr_q) ? perf_instr_q + 16'd1 : perf_instr_q;
    perf_stall_d = clr ? '0 : (instr_valid & stall & ~&perf_stall_q) ? perf_stall_q + 16'd1 : perf_stall_q;
    perf_instr   = perf_instr_q;
    perf_stall   = perf_stall_q;
  end

  // counter registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      perf_instr_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_instr_q <= perf_instr_d;
      perf_stall_q <= perf_stall_d;
    end
  end
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: scoreboard bench; expected stream = memory words from the fetch origin up to the first zero word
module tb_fetch_sequencer;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          Clk = 1'b0, Reset_n = 1'b0, start = 1'b0, stall = 1'b0, redirect = 1'b0;
  logic [AW-1:0] redirect_addr = '0;
  logic [AW-1:0] mem_addr, instr_pc;
  logic [DW-1:0] mem_data, instr;
  logic          instr_valid, busy, halted;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0]   perf_instr, perf_stall;
`endif

  logic [DW-1:0] mem [1024];
  typedef struct packed {logic [AW-1:0] pc; logic [DW-1:0] w;} exp_t;
  exp_t q[$];
  exp_t e_m;
  int tests = 0, fails = 0;

  fetch_sequencer dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .stall(stall), .redirect(redirect),
    .redirect_addr(redirect_addr), .mem_addr(mem_addr), .mem_data(mem_data), .instr(instr),
    .instr_pc(instr_pc), .instr_valid(instr_valid), .busy(busy), .halted(halted)
`ifdef FETCH_PERF_CNT_EN
    , .perf_instr(perf_instr), .perf_stall(perf_stall)
`endif
  );

  always #5 Clk = ~Clk;

  // synchronous-read instruction memory
  always @(posedge Clk) mem_data <= mem[mem_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference: from address a the decode stage sees mem[a], mem[a+1], ... until a zero word
  task automatic push_seq(input logic [AW-1:0] a);
    q.delete();
    for (int n = 0; n < 1024; n++) begin
      if (mem[a] == '0) break;
      q.push_back({a, mem[a]});
      a = a + 1'b1;
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic run_to_halt(input int bound);
    for (int n = 0; n < bound && !halted; n++) step();
    chk("halted_reached", 32'(halted), 32'd1);
    chk("queue_drained", 32'(q.size()), 32'd0);
  endtask

  task automatic do_start();
    start = 1'b1;
    push_seq('0);
    step();
    start = 1'b0;
    #1;
  endtask

  // monitor: every transfer must match the head of the expected stream
  always @(negedge Clk) begin
    if (Reset_n && instr_valid && !stall) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_xfer: got pc %h expected none", instr_pc);
      end else begin
        e_m = q.pop_front();
        chk("xfer_pc", 32'(instr_pc), 32'(e_m.pc));
        chk("xfer_instr", instr, e_m.w);
      end
    end
  end

  initial begin
    logic [DW-1:0] prog [8];
    prog = '{32'h23E01500, 32'h00A00093, 32'h00B00113, 32'h002081B3,
             32'h1C01214B, 32'h40310233, 32'h00402023, 32'h0000006F};
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    for (int i = 0; i < 8; i++) mem[i] = prog[i];
    for (int i = 12; i < 15; i++) mem[i] = 32'hC0DE0000 + 32'(i);
    mem[1022] = 32'hAAAA1022;
    mem[1023] = 32'hAAAA1023;
    #1;
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_pc", 32'(instr_pc), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    step();
    Reset_n = 1'b1;
    step();
    #1;
    chk("idle_busy", 32'(busy), 0);
    // start test
    do_start();
    for (int i = 0; i < 8; i++) begin
      chk("start_valid", 32'(instr_valid), 1);
      chk("start_pc", 32'(instr_pc), 32'(i));
      if (i == 0) chk("start_instr0", instr, 32'h23E01500);
      step();
    end
    chk("zero_not_valid", 32'(instr_valid), 0);
    step();
    chk("halted_after_prog", 32'(halted), 1);
    chk("halted_busy", 32'(busy), 0);
    chk("start_drained", 32'(q.size()), 0);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_instr", 32'(perf_instr), 8);
`endif
    // stall test
    do_start();
    for (int i = 0; i < 4; i++) step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_pc", 32'(instr_pc), 4);
      chk("stall_instr", instr, 32'h1C01214B);
      chk("stall_valid", 32'(instr_valid), 1);
      step();
    end
    stall = 1'b0;
    step();
    chk("after_stall_pc", 32'(instr_pc), 5);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_stall", 32'(perf_stall), 3);
`endif
    run_to_halt(40);
    // redirect test
    do_start();
    step();
    step();
    chk("pre_redirect_pc", 32'(instr_pc), 2);
    redirect = 1'b1;
    redirect_addr = 10'd12;
    push_seq(10'd12);
    #1;
    chk("redirect_squash", 32'(instr_valid), 0);
    step();
    redirect = 1'b0;
    #1;
    for (int i = 12; i < 15; i++) begin
      chk("redirect_valid", 32'(instr_valid), 1);
      chk("redirect_pc", 32'(instr_pc), 32'(i));
      step();
    end
    run_to_halt(20);
    // redirect beats stall
    do_start();
    step();
    stall = 1'b1;
    redirect = 1'b1;
    redirect_addr = 10'd13;
    push_seq(10'd13);
    step();
    stall = 1'b0;
    redirect = 1'b0;
    #1;
    chk("prio_pc", 32'(instr_pc), 13);
    chk("prio_valid", 32'(instr_valid), 1);
    run_to_halt(20);
    // wrap test
    do_start();
    redirect = 1'b1;
    redirect_addr = 10'd1022;
    push_seq(10'd1022);
    step();
    redirect = 1'b0;
    #1;
    chk("wrap_pc0", 32'(instr_pc), 1022);
    step();
    chk("wrap_pc1", 32'(instr_pc), 1023);
    step();
    chk("wrap_pc2", 32'(instr_pc), 0);
    run_to_halt(40);
    // reset mid-run
    do_start();
    step();
    Reset_n = 1'b0;
    #1;
    chk("areset_valid", 32'(instr_valid), 0);
    chk("areset_busy", 32'(busy), 0);
    chk("areset_mem_addr", 32'(mem_addr), 0);
    q.delete();
    step();
    Reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_reset_idle", 32'(busy), 0);
    end
    do_start();
    chk("restart_pc", 32'(instr_pc), 0);
    chk("restart_valid", 32'(instr_valid), 1);
    run_to_halt(40);
    // randomized run against the stream model
    for (int c = 0; c < 4000; c++) begin
      step();
      start = 1'b0;
      redirect = 1'b0;
      stall = 1'b0;
      if (!busy) begin
        if (c % 7 == 0) begin
          for (int i = 0; i < 1024; i++) mem[i] = ($urandom_range(0, 15) == 0) ? '0 : ($urandom | 32'd1);
        end
        if ($urandom_range(0, 2) == 0) begin
          chk("rand_drained", 32'(q.size()), 0);
          start = 1'b1;
          push_seq('0);
        end
      end else begin
        stall = $urandom_range(0, 2) == 0;
        if ($urandom_range(0, 9) == 0) begin
          redirect = 1'b1;
          redirect_addr = AW'($urandom);
          push_seq(redirect_addr);
        end
      end
    end
    step();
    start = 1'b0;
    redirect = 1'b0;
    stall = 1'b0;
    if (busy || q.size() != 0) run_to_halt(3000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
